// File: rtl/lava_pkg.sv
// Shared definitions for the lava-lamp HUB75 display path.
// Holds the panel geometry, the pixel field layout {R[3:0],G[3:0],B[3:0]},
// the scan FSM state type and a helper that picks one bit plane out of a pixel.
package lava_pkg;

    localparam int unsigned COLS      = 64;
    localparam int unsigned HALF_ROWS = 16;
    localparam int unsigned BPC       = 4;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned PX_W      = 12;

    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned ROW_W   = $clog2(HALF_ROWS);
    localparam int unsigned PLANE_W = $clog2(BPC);

    // Colour field offsets inside a pixel word.
    localparam int unsigned R_OFS = 8;
    localparam int unsigned G_OFS = 4;
    localparam int unsigned B_OFS = 0;

    typedef enum logic [1:0] {
        SHIFT,
        LATCH,
        GUARD,
        DISPLAY
    } scan_state_t;

    // {R,G,B} bit of the requested plane.
    function automatic logic [2:0] plane_bits(input logic [PX_W-1:0]    px,
                                              input logic [PLANE_W-1:0] plane);
        logic [BPC-1:0] r;
        logic [BPC-1:0] g;
        logic [BPC-1:0] b;
        r = px[R_OFS +: BPC];
        g = px[G_OFS +: BPC];
        b = px[B_OFS +: BPC];
        return {r[plane], g[plane], b[plane]};
    endfunction

endpackage

// File: rtl/bcm_timer.sv
// Loadable down-counter used to time BCM display windows and the ghost guard.
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_load     load i_load_val (takes priority over counting)
//   i_load_val window length in cycles (>= 1)
//   o_done     high on the last cycle of the loaded window
// A load on cycle t gives a window of i_load_val cycles starting at t+1.
module bcm_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/hub75_scan.sv
// HUB75 scan-out engine: reads the top/bottom display buffers (1-cycle read
// latency) and drives a 64x32 panel with 4-plane binary code modulation.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_din_top, i_din_btm    buffer read data {R,G,B} nibbles, valid 1 cycle after o_r_addr
//   o_r_addr                shared read address {row, col}
//   o_sclk, o_latch         panel shift clock and latch strobe
//   o_blank                 panel output enable, high = LEDs off
//   o_dout_top, o_dout_btm  {R,G,B} bit of the current plane
//   o_row_sel               panel row address
//   o_frame_done            1-cycle pulse at the end of every full frame
// Optional: define LAVA_GHOST_GUARD_EN to insert GUARD_CYCLES blanked cycles
// between LATCH and DISPLAY.
module hub75_scan
    import lava_pkg::*;
#(
    parameter int unsigned SCLK_DIV     = 2,
    parameter int unsigned BASE_TICKS   = 64,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [PX_W-1:0]   i_din_top,
    input  logic [PX_W-1:0]   i_din_btm,
    output logic [ADDR_W-1:0] o_r_addr,
    output logic              o_sclk,
    output logic              o_latch,
    output logic              o_blank,
    output logic [2:0]        o_dout_top,
    output logic [2:0]        o_dout_btm,
    output logic [ROW_W-1:0]  o_row_sel,
    output logic              o_frame_done
);

    localparam int unsigned SLOT      = 2 * SCLK_DIV;
    localparam int unsigned PH_W      = $clog2(SLOT);
    localparam int unsigned MAX_TICKS = BASE_TICKS << (BPC - 1);
    localparam int unsigned TMR_MAX   = (MAX_TICKS > GUARD_CYCLES) ? MAX_TICKS : GUARD_CYCLES;
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [ROW_W-1:0]   r_row;
    logic [ROW_W-1:0]   r_row_sel;
    logic [PLANE_W-1:0] r_plane;
    logic [COL_W-1:0]   r_col;
    logic [COL_W-1:0]   w_col_inc;
    logic [PH_W-1:0]    r_phase;
    logic               r_pre;   // SHIFT prefetch cycle
    logic               r_lat;   // second LATCH cycle
    logic [2:0]         r_dout_top;
    logic [2:0]         r_dout_btm;
    logic [2:0]         w_dout_top;
    logic [2:0]         w_dout_btm;
    logic               w_slot_start;
    logic               w_slot_end;
    logic               w_last_col;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_done;

    assign w_col_inc    = r_col + 1'b1;
    assign w_slot_end   = (r_phase == PH_W'(SLOT - 1));
    assign w_slot_start = (r_state == SHIFT) && !r_pre && (r_phase == '0);
    assign w_last_col   = (r_col == COL_W'(COLS - 1));

    bcm_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SHIFT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            SHIFT: begin
                if (!r_pre && w_slot_end && w_last_col) begin
                    w_state_nxt = LATCH;
                end
            end
            LATCH: begin
                if (r_lat) begin
`ifdef LAVA_GHOST_GUARD_EN
                    w_state_nxt = GUARD;
`else
                    w_state_nxt = DISPLAY;
`endif
                end
            end
`ifdef LAVA_GHOST_GUARD_EN
            GUARD: begin
                if (w_tmr_done) begin
                    w_state_nxt = DISPLAY;
                end
            end
`endif
            DISPLAY: begin
                if (w_tmr_done) begin
                    w_state_nxt = SHIFT;
                end
            end
            default: w_state_nxt = SHIFT;
        endcase
    end

    // Outputs and timer control.
    always_comb begin
        o_sclk       = 1'b0;
        o_latch      = 1'b0;
        o_blank      = 1'b1;
        o_frame_done = 1'b0;
        o_r_addr     = {r_row, COL_W'(0)};
        w_tmr_load   = 1'b0;
        w_tmr_val    = TMR_W'(BASE_TICKS) << r_plane;
        unique case (r_state)
            SHIFT: begin
                o_sclk = !r_pre && (r_phase >= PH_W'(SCLK_DIV));
                // Present the next column on the last slot cycle so its data
                // lands exactly at the next slot start.
                o_r_addr = {r_row, (!r_pre && w_slot_end) ? w_col_inc : r_col};
            end
            LATCH: begin
                o_latch    = !r_lat;
                w_tmr_load = r_lat;
`ifdef LAVA_GHOST_GUARD_EN
                w_tmr_val  = TMR_W'(GUARD_CYCLES);
`endif
            end
`ifdef LAVA_GHOST_GUARD_EN
            GUARD: begin
                w_tmr_load = w_tmr_done;
            end
`endif
            DISPLAY: begin
                o_blank      = 1'b0;
                o_frame_done = w_tmr_done && (r_row == ROW_W'(HALF_ROWS - 1)) && (r_plane == '0);
            end
            default: ;
        endcase
    end

    // Data bits are taken straight from the buffer at slot start and held after.
    always_comb begin
        w_dout_top = r_dout_top;
        w_dout_btm = r_dout_btm;
        if (w_slot_start) begin
            w_dout_top = plane_bits(i_din_top, r_plane);
            w_dout_btm = plane_bits(i_din_btm, r_plane);
        end
    end

    assign o_dout_top = w_dout_top;
    assign o_dout_btm = w_dout_btm;
    assign o_row_sel  = r_row_sel;

    // Scan counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row      <= '0;
            r_plane    <= PLANE_W'(BPC - 1);
            r_col      <= '0;
            r_phase    <= '0;
            r_pre      <= 1'b1;
            r_lat      <= 1'b0;
            r_row_sel  <= '0;
            r_dout_top <= '0;
            r_dout_btm <= '0;
        end else begin
            r_dout_top <= w_dout_top;
            r_dout_btm <= w_dout_btm;
            unique case (r_state)
                SHIFT: begin
                    if (r_pre) begin
                        r_pre <= 1'b0;
                    end else if (w_slot_end) begin
                        r_phase <= '0;
                        r_col   <= w_col_inc;  // wraps to 0 after the last column
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                    if (w_state_nxt == LATCH) begin
                        r_row_sel <= r_row;
                    end
                end
                LATCH: begin
                    r_lat <= ~r_lat;
                end
                DISPLAY: begin
                    if (w_tmr_done) begin
                        r_pre <= 1'b1;
                        if (r_plane == '0) begin
                            r_plane <= PLANE_W'(BPC - 1);
                            r_row   <= r_row + 1'b1;
                        end else begin
                            r_plane <= r_plane - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan.sv
// Scoreboard bench for hub75_scan: a frame-level reference model pushes the
// expected serial bits, latch rows and blank-low window lengths into queues,
// and a monitor pops and compares them as the DUT produces each event.
module tb_hub75_scan;

    localparam int SCLK_DIV     = 2;
    localparam int BASE_TICKS   = 64;
    localparam int GUARD_CYCLES = 4;
`ifdef LAVA_GHOST_GUARD_EN
    localparam int G = GUARD_CYCLES;
`else
    localparam int G = 0;
`endif
    localparam int SHIFT_LEN = 1 + 64 * 2 * SCLK_DIV;
    localparam int PERIOD    = 16 * (4 * (SHIFT_LEN + 2 + G) + BASE_TICKS * 15);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] din_top = '0;
    logic [11:0] din_btm = '0;
    logic [9:0]  r_addr;
    logic        sclk;
    logic        latch;
    logic        blank;
    logic [2:0]  dout_top;
    logic [2:0]  dout_btm;
    logic [3:0]  row_sel;
    logic        frame_done;

    hub75_scan #(
        .SCLK_DIV     (SCLK_DIV),
        .BASE_TICKS   (BASE_TICKS),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_din_top    (din_top),
        .i_din_btm    (din_btm),
        .o_r_addr     (r_addr),
        .o_sclk       (sclk),
        .o_latch      (latch),
        .o_blank      (blank),
        .o_dout_top   (dout_top),
        .o_dout_btm   (dout_btm),
        .o_row_sel    (row_sel),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Display buffers with one cycle of read latency.
    logic [11:0] top_mem [1024];
    logic [11:0] btm_mem [1024];
    always @(posedge clk) begin
        din_top <= top_mem[r_addr];
        din_btm <= btm_mem[r_addr];
    end

    int q_data[$];  // expected top*8 + btm per sclk edge
    int q_row[$];   // expected row_sel per latch
    int q_win[$];   // expected blank-low length per display window

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame order is rows 0..15, planes 3..0, columns 0..63.
    task automatic push_frame();
        int px_t;
        int px_b;
        int et;
        int eb;
        for (int r = 0; r < 16; r++) begin
            for (int p = 3; p >= 0; p--) begin
                for (int c = 0; c < 64; c++) begin
                    px_t = int'(top_mem[r * 64 + c]);
                    px_b = int'(btm_mem[r * 64 + c]);
                    et = (((px_t / 256) >> p) & 1) * 4 + ((((px_t / 16) % 16) >> p) & 1) * 2
                         + (((px_t % 16) >> p) & 1);
                    eb = (((px_b / 256) >> p) & 1) * 4 + ((((px_b / 16) % 16) >> p) & 1) * 2
                         + (((px_b % 16) >> p) & 1);
                    q_data.push_back(et * 8 + eb);
                end
                q_row.push_back(r);
                q_win.push_back(BASE_TICKS << p);
            end
        end
    endtask

    // Monitor state.
    int cyc;
    int p_sclk, p_latch, p_blank, p_row_sel;
    int edges, n_latch, lat_cyc, win_start, last_fd, fd_cnt;
    int cap_top [4];
    int cap_btm [4];

    initial begin
        int exp_v;
        int cur_row;
        int cur_plane;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc       = -1;
                p_sclk    = 0;
                p_latch   = 0;
                p_blank   = 1;
                p_row_sel = 0;
                edges     = 0;
                n_latch   = 0;
                lat_cyc   = -100;
                win_start = 0;
                last_fd   = -1;
                fd_cnt    = 0;
                for (int i = 0; i < 4; i++) begin
                    cap_top[i] = -1;
                    cap_btm[i] = -1;
                end
            end else begin
                cyc++;
                cur_row   = (n_latch / 4) % 16;
                cur_plane = 3 - (n_latch % 4);
                if (sclk && p_sclk == 0) begin
                    check("data_queue_nonempty", int'(q_data.size() != 0), 1);
                    if (q_data.size() != 0) begin
                        exp_v = q_data.pop_front();
                        check("dout_top", int'(dout_top), exp_v / 8);
                        check("dout_btm", int'(dout_btm), exp_v % 8);
                    end
                    if (edges == 5 && cur_row == 0) begin
                        cap_top[cur_plane] = int'(dout_top);
                        cap_btm[cur_plane] = int'(dout_btm);
                    end
                    edges++;
                end
                if (latch) check("blank_during_latch", int'(blank), 1);
                if (latch && p_latch == 0) begin
                    check("sclk_edges_per_shift", edges, 64);
                    edges = 0;
                    check("row_queue_nonempty", int'(q_row.size() != 0), 1);
                    if (q_row.size() != 0) check("latch_row_sel", int'(row_sel), q_row.pop_front());
                    lat_cyc = cyc;
                    n_latch++;
                end
                if (!latch && p_latch == 1) check("latch_width", cyc - lat_cyc, 1);
                if (!blank && p_blank == 1) begin
                    check("latch_to_display_gap", cyc - lat_cyc, 2 + G);
                    win_start = cyc;
                end
                if (blank && p_blank == 0) begin
                    check("win_queue_nonempty", int'(q_win.size() != 0), 1);
                    if (q_win.size() != 0) check("blank_low_len", cyc - win_start, q_win.pop_front());
                end
                if (int'(row_sel) != p_row_sel) check("blank_on_row_change", int'(blank), 1);
                if (frame_done) begin
                    check("frame_period", cyc - last_fd, PERIOD);
                    last_fd = cyc;
                    fd_cnt++;
                end
                p_sclk    = int'(sclk);
                p_latch   = int'(latch);
                p_blank   = int'(blank);
                p_row_sel = int'(row_sel);
            end
        end
    end

    // Reset, reload both buffers and the scoreboard, then check reset values
    // and the first sclk edge.
    task automatic do_reset(input bit phase_b);
        int k;
        @(posedge clk);
        #2;
        rst = 1'b1;
        q_data.delete();
        q_row.delete();
        q_win.delete();
        for (int i = 0; i < 1024; i++) begin
            top_mem[i] = 12'($urandom);
            btm_mem[i] = 12'($urandom);
        end
        if (!phase_b) begin
            top_mem[5] = 12'hF00;
            btm_mem[5] = 12'h00F;
            push_frame();
            push_frame();
        end else begin
            btm_mem[5] = 12'h001;
            push_frame();
        end
        @(posedge clk);
        #2;
        check("rst_blank", int'(blank), 1);
        check("rst_sclk", int'(sclk), 0);
        check("rst_latch", int'(latch), 0);
        check("rst_row_sel", int'(row_sel), 0);
        check("rst_r_addr", int'(r_addr), 0);
        check("rst_dout_top", int'(dout_top), 0);
        check("rst_dout_btm", int'(dout_btm), 0);
        check("rst_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #2;
            if (sclk) begin
                k = i;
                break;
            end
        end
        check("first_sclk_delay", k, SCLK_DIV + 1);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (fd_cnt >= n) break;
        end
        check("frame_done_in_time", int'(fd_cnt >= n), 1);
    endtask

    initial begin
        int i;
        for (int j = 0; j < 1024; j++) begin
            top_mem[j] = '0;
            btm_mem[j] = '0;
        end
        repeat (3) @(posedge clk);

        // Phase A: one full frame, then into frame 2 up to row 7, plane 1.
        do_reset(1'b0);
        wait_frames(1, PERIOD + 100);
        check("cap_top_p3", cap_top[3], 4);
        check("cap_btm_p3", cap_btm[3], 1);
        check("cap_btm_p0", cap_btm[0], 1);
        for (i = 0; i < PERIOD; i++) begin
            @(posedge clk);
            #2;
            if (n_latch >= 64 + 31) break;
        end
        check("reach_row7_plane1", int'(n_latch >= 64 + 31), 1);
        for (i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (!blank) break;
        end
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        check("pre_rst_blank_low", int'(blank), 0);
        check("pre_rst_row_sel", int'(row_sel), 7);

        // Phase B: reset mid-display, new buffer contents, one full frame.
        do_reset(1'b1);
        wait_frames(1, PERIOD + 100);
        @(posedge clk);
        #2;
        check("data_queue_drained", q_data.size(), 0);
        check("row_queue_drained", q_row.size(), 0);
        check("win_queue_drained", q_win.size(), 0);
        check("capb_btm_p0", cap_btm[0], 1);
        check("capb_btm_p1", cap_btm[1], 0);
        check("capb_btm_p3", cap_btm[3], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hub75_scan.md
Name: hub75_scan

Overview:
- Reader end of the lava-lamp frame buffers: scans the top and bottom halves of the 64x32 HUB75 panel out of the two 1024x12 display buffers.
- Drives the panel's serial shift, latch, blank and row-select pins.
- Uses binary code modulation (BCM) over 4 bit planes per colour channel.
- Sits between top_buff/btm_buff (synchronous read, 1-cycle latency) and the panel pins.

Parameters:
- SCLK_DIV, 2: sclk half-period in clk cycles (>=1).
- BASE_TICKS, 64: display time of the LSB plane in clk cycles; plane p displays BASE_TICKS<<p cycles.
- GUARD_CYCLES, 4: extra blanked cycles after latch (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- din_top  in  12  top-buffer read data {R[3:0],G[3:0],B[3:0]}, valid 1 cycle after r_addr
- din_btm  in  12  bottom-buffer read data, same format and timing
- r_addr  out  10  shared read address = {row[3:0], col[5:0]}
- sclk  out  1  panel shift clock
- latch  out  1  panel latch strobe
- blank  out  1  panel output enable, active high = LEDs off
- dout_top  out  3  {R,G,B} bit of current plane, top half
- dout_btm  out  3  {R,G,B} bit of current plane, bottom half
- row_sel  out  4  panel row address
- frame_done  out  1  1-cycle pulse at end of each full frame

Behaviour:
- Reset values (cycle after rst sampled high): sclk=0, latch=0, blank=1, dout_top=dout_btm=0, row_sel=0, r_addr=0, frame_done=0; FSM in SHIFT with row=0, plane=3, col=0.
- FSM states: SHIFT -> LATCH -> (GUARD) -> DISPLAY -> SHIFT.
- Plane order within a row: 3,2,1,0. After plane 0, row increments; row 15 wraps to 0.
- SHIFT: blank=1. Lasts exactly 1 + 64*2*SCLK_DIV cycles.
  - Cycle 0 is prefetch: r_addr={row,0}.
  - Each column then occupies a 2*SCLK_DIV slot. At slot start, dout_* = {din[8+p], din[4+p], din[p]} and sclk=0. sclk rises at SCLK_DIV into the slot.
  - r_addr advances so data for col c+1 is present at the start of slot c+1.
  - Exactly 64 sclk rising edges per SHIFT. sclk=0 on exit.
- LATCH: 2 cycles, blank=1.
  - Cycle 0: latch=1 and row_sel<=row, updated in the same cycle.
  - Cycle 1: latch=0.
- DISPLAY: blank=0 for BASE_TICKS<<plane cycles; dout_* hold; sclk=0.
  - On the last cycle, advance plane/row.
  - frame_done=1 on the last DISPLAY cycle of row 15, plane 0.
- blank rises on the first SHIFT cycle after DISPLAY. blank is never low while latch=1 or while row_sel changes.
- Display counter width: enough bits for BASE_TICKS<<3. Column counter 6 bits, row 4 bits, plane 2 bits, all wrapping.
- Default frame period: 16*(4*(257+2) + 64*15) = 31936 cycles.
- rst mid-operation (any state): all outputs return to reset values the next cycle. Any partially shifted row is discarded; scan restarts at row 0, plane 3.
- Buffer swaps are owned by the writer. This block is oblivious to them; a swap is visible from the next read.

Optional Feature:
- Macro: LAVA_GHOST_GUARD_EN.
- Defined: GUARD state of GUARD_CYCLES cycles between LATCH and DISPLAY; blank=1, all other outputs held. Frame period grows by 64*GUARD_CYCLES.
- Undefined: LATCH goes directly to DISPLAY; the GUARD state and the GUARD_CYCLES logic are absent.

Decomposition:
- Shared package lava_pkg holds:
  - localparams COLS=64, HALF_ROWS=16, BPC=4, ADDR_W=10, PX_W=12;
  - the R/G/B field offsets (8, 4, 0);
  - typedef enum scan_state_t {SHIFT, LATCH, GUARD, DISPLAY}.
- One sub-module, bcm_timer: a loadable down-counter (load value BASE_TICKS<<plane) with a done pulse. It is reused for the DISPLAY and GUARD durations.

Test Plan:
- Reset: after rst, check blank=1, sclk=0, latch=0, row_sel=0, r_addr=0. The first sclk rising edge occurs SCLK_DIV+1 cycles after reset deasserts.
- Data path: with a 1-cycle-latency buffer model, set top[{0,5}]=12'hF00 and btm[{0,5}]=12'h00F. On the 6th sclk edge of plane 3, row 0, require dout_top=3'b100 and dout_btm=3'b001. With btm[{0,5}]=12'h001, the 6th edge shows dout_btm=3'b001 only in plane 0.
- Timing: per row, require 4 latch pulses, each SHIFT with 64 sclk edges, and blank-low windows of 512, 256, 128 and 64 cycles in that order. blank=1 whenever latch=1.
- Scan order: row_sel steps 0..15 then wraps to 0; frame_done pulses every 31936 cycles with defaults.
- Reset mid-DISPLAY of row 7, plane 1: next cycle blank=1 and row_sel=0. The next latch carries row_sel=0 after a full plane-3 SHIFT.
- With LAVA_GHOST_GUARD_EN and GUARD_CYCLES=4: require 4 extra blank-high cycles after each latch; frame_done period is 32192.
